// File: rtl/booth_mult_ctrl.sv
// Sequencing controller for a radix-2 Booth multiplier datapath.
// Walks LOAD -> (EVAL, SHIFT) x DATA_WIDTH -> DONE, with valid/ready handshakes at both ends.
module booth_mult_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 q0,
  input  logic                 q_m1,
  input  logic                 flush,
  output logic                 ld,
  output logic                 add_en,
  output logic                 sub_en,
  output logic                 shift_en,
  output logic                 busy,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [CNT_WIDTH-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] iter_cnt_q, iter_cnt_d;

  // Next-state and counter update; flush overrides both handshakes.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    if (flush) begin
      state_d    = S_IDLE;
      iter_cnt_d = CNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid) state_d = S_LOAD;
          else             state_d = S_IDLE;
        end
        S_LOAD: begin
          state_d    = S_EVAL;
          iter_cnt_d = CNT_LOAD;
        end
        S_EVAL: begin
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          // Saturate at zero; <= also recovers from an unexpected zero count.
          if (iter_cnt_q != CNT_ZERO) iter_cnt_d = iter_cnt_q - CNT_ONE;
          else                        iter_cnt_d = CNT_ZERO;
          if (iter_cnt_q <= CNT_ONE) state_d = S_DONE;
          else                       state_d = S_EVAL;
        end
        S_DONE: begin
          if (done_ready) state_d = S_IDLE;
          else            state_d = S_DONE;
        end
        default: begin
          state_d    = S_IDLE;
          iter_cnt_d = CNT_ZERO;
        end
      endcase
    end
  end

  // State and iteration counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      iter_cnt_q <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  // Control strobes decoded straight from the state so async reset clears them at once.
  assign start_ready = (state_q == S_IDLE);
  assign ld          = (state_q == S_LOAD);
  assign shift_en    = (state_q == S_SHIFT);
  assign busy        = (state_q == S_LOAD) || (state_q == S_EVAL) || (state_q == S_SHIFT);
  assign done_valid  = (state_q == S_DONE);
  assign add_en      = (state_q == S_EVAL) && !q0 && q_m1;
  assign sub_en      = (state_q == S_EVAL) && q0 && !q_m1;
  assign iter_cnt    = iter_cnt_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed bench for booth_mult_ctrl: a per-cycle expected-output scoreboard is filled
// when a start is driven and drained one entry per clock, for DATA_WIDTH 4 and 8.
module tb_booth_mult_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, q0, q_m1;
  logic       sv4, sr4, ld4, add4, sub4, sh4, busy4, dv4, dr4, fl4;
  logic [2:0] cnt4;
  logic       sv8, sr8, ld8, add8, sub8, sh8, busy8, dv8, dr8, fl8;
  logic [3:0] cnt8;

  booth_mult_ctrl #(.DATA_WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4), .q0(q0), .q_m1(q_m1),
    .flush(fl4), .ld(ld4), .add_en(add4), .sub_en(sub4), .shift_en(sh4), .busy(busy4),
    .done_valid(dv4), .done_ready(dr4), .iter_cnt(cnt4)
  );

  booth_mult_ctrl #(.DATA_WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8), .q0(q0), .q_m1(q_m1),
    .flush(fl8), .ld(ld8), .add_en(add8), .sub_en(sub8), .shift_en(sh8), .busy(busy8),
    .done_valid(dv8), .done_ready(dr8), .iter_cnt(cnt8)
  );

  typedef struct packed {
    logic       ld, add, sub, sh, busy, sr, dv;
    logic [3:0] cnt;
  } vec_t;

  typedef struct packed {
    vec_t       e;
    logic [1:0] q;
  } item_t;

  item_t sb[$];
  int    vectors = 0;
  int    fails   = 0;

  function automatic vec_t mk(logic l, logic a, logic s, logic h, logic b, logic r, logic d,
                              logic [3:0] c);
    vec_t v;
    v.ld = l; v.add = a; v.sub = s; v.sh = h; v.busy = b; v.sr = r; v.dv = d; v.cnt = c;
    return v;
  endfunction

  function automatic vec_t observe(int which);
    if (which == 4) return mk(ld4, add4, sub4, sh4, busy4, sr4, dv4, {1'b0, cnt4});
    else            return mk(ld8, add8, sub8, sh8, busy8, sr8, dv8, cnt8);
  endfunction

  task automatic check_vec(string tag, int which, vec_t exp);
    vec_t act;
    act = observe(which);
    vectors++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s (dw%0d): observed %b expected %b [ld add sub sh busy sr dv cnt]",
             tag, which, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sv(int which, logic v);
    if (which == 4) sv4 = v;
    else            sv8 = v;
  endtask

  // Expected outputs for every cycle from LOAD through the first DONE cycle.
  task automatic push_op(int n, logic [15:0] pat);
    item_t it;
    logic [1:0] p;
    it.e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); it.q = 2'b00;
    sb.push_back(it);
    for (int i = 1; i <= n; i++) begin
      p = pat[2*(i-1) +: 2];
      it.e = mk(1'b0, p == 2'b01, p == 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 4'(n - i + 1));
      it.q = p;
      sb.push_back(it);
      it.e = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'(n - i + 1));
      it.q = 2'b00;
      sb.push_back(it);
    end
    it.e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0); it.q = 2'b00;
    sb.push_back(it);
  endtask

  // Starts an operation from IDLE and checks every cycle up to the first DONE cycle.
  task automatic run_op(int which, logic [15:0] pat);
    item_t it;
    int    cyc;
    set_sv(which, 1'b1);
    push_op(which, pat);
    cyc = 0;
    while (sb.size() > 0) begin
      tick();
      set_sv(which, 1'b0);
      it   = sb.pop_front();
      q0   = it.q[1];
      q_m1 = it.q[0];
      #1;
      cyc++;
      check_vec($sformatf("op_cycle_k+%0d", cyc), which, it.e);
    end
  endtask

  task automatic finish_done(int which);
    if (which == 4) dr4 = 1'b1; else dr8 = 1'b1;
    tick();
    dr4 = 1'b0; dr8 = 1'b0;
    check_vec("idle_after_done", which, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t idle_v, done_v;
    idle_v = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    done_v = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    rst = 1'b0; q0 = 1'b0; q_m1 = 1'b0;
    sv4 = 1'b1; dr4 = 1'b0; fl4 = 1'b0;
    sv8 = 1'b0; dr8 = 1'b0; fl8 = 1'b0;

    // Reset held while clocking with start_valid asserted.
    repeat (3) tick();
    check_vec("reset", 4, idle_v);
    check_vec("reset", 8, idle_v);
    rst = 1'b1;

    // Booth pairs 10,11,01,00 then a long DONE stall with start_valid high.
    run_op(4, 16'h001E);
    sv4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec($sformatf("done_hold_%0d", i), 4, done_v);
    end
    dr4 = 1'b1;
    tick();
    dr4 = 1'b0;
    check_vec("idle_after_done_hs", 4, idle_v);
    tick();
    sv4 = 1'b0;
    check_vec("restart_load", 4, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));

    // Continue that op into the second SHIFT, then flush.
    q0 = 1'b0; q_m1 = 1'b0;
    repeat (3) tick();
    tick();
    check_vec("shift2", 4, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3));
    fl4 = 1'b1;
    tick();
    fl4 = 1'b0;
    check_vec("flush_to_idle", 4, idle_v);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec($sformatf("no_done_after_flush_%0d", i), 4, idle_v);
    end
    sv4 = 1'b1; fl4 = 1'b1;
    tick();
    sv4 = 1'b0; fl4 = 1'b0;
    check_vec("flush_beats_start", 4, idle_v);
    tick();
    check_vec("flush_beats_start_2", 4, idle_v);

    // Async reset while add_en is high in EVAL.
    sv4 = 1'b1;
    tick();
    sv4 = 1'b0;
    tick();
    q0 = 1'b0; q_m1 = 1'b1;
    #1;
    check_vec("eval_add", 4, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4));
    #1 rst = 1'b0;
    #1;
    check_vec("async_reset", 4, idle_v);
    tick();
    rst = 1'b1;
    run_op(4, 16'h0099);
    finish_done(4);

    // A randomly chosen Booth-pair sequence.
    run_op(4, 16'($urandom));
    finish_done(4);

    // Eight-iteration instance.
    run_op(8, 16'h4B2D);
    finish_done(8);
    check_vec("dw4_idle_end", 4, idle_v);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/booth_mult_ctrl.md
Name: booth_mult_ctrl

Overview:
- Sequencing controller for the radix-2 Booth multiplier datapath.
- Accepts a start request through a valid/ready handshake and commands the operand/accumulator load.
- Runs DATA_WIDTH evaluate/shift iterations from the datapath Booth bit pair {q0,q_m1}, driving add, subtract and arithmetic-shift strobes.
- Holds an iteration counter and presents completion through a second valid/ready handshake.

Parameters:
DATA_WIDTH, 4, operand width; equals the number of Booth iterations.
CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width; must hold the value DATA_WIDTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
start_valid  input  1  requester has operands ready in the datapath
start_ready  output  1  controller can accept a start (IDLE only)
q0  input  1  LSB of the multiplier/Q register from the datapath
q_m1  input  1  Q(-1) extension bit from the datapath
flush  input  1  synchronous abort; returns the controller to IDLE
ld  output  1  load operands, clear accumulator and Q(-1); one-cycle pulse
add_en  output  1  accumulator += multiplicand this cycle
sub_en  output  1  accumulator -= multiplicand this cycle
shift_en  output  1  arithmetic right shift of {A,Q,Q(-1)} this cycle
busy  output  1  high in LOAD, EVAL and SHIFT
done_valid  output  1  product in the datapath is final
done_ready  input  1  consumer accepts the product
iter_cnt  output  CNT_WIDTH  remaining iterations

Behaviour:
- Reset (rst low, asynchronous): state is IDLE and iter_cnt is 0. start_ready is 1. All other outputs are 0.
- The state register and iter_cnt are the only flops.
- ld, shift_en, busy, start_ready and done_valid are Moore decodes of the state.
- add_en and sub_en are decoded in EVAL from {q0,q_m1}.
- States and transitions:
  - IDLE: start_ready=1. When start_valid & start_ready is sampled at an edge, go to LOAD.
  - LOAD: ld=1, busy=1, iter_cnt <= DATA_WIDTH, then go to EVAL.
  - EVAL: busy=1, one cycle, then go to SHIFT. Strobes by {q0,q_m1}:
    - 10: sub_en=1.
    - 01: add_en=1.
    - 00 or 11: no strobe.
  - SHIFT: shift_en=1, busy=1, iter_cnt <= iter_cnt-1. If iter_cnt==1, go to DONE; otherwise go to EVAL.
  - DONE: done_valid=1, start_ready=0. When done_ready is sampled high, go to IDLE. done_valid is held until that handshake.
- Latency: a start handshake at edge k gives ld high after edge k and done_valid high after edge k+2*DATA_WIDTH+1. For DATA_WIDTH=4 this is edge k+9.
- Exactly DATA_WIDTH shift_en pulses and DATA_WIDTH EVAL cycles occur per operation.
- add_en and sub_en are never high together, and never high outside EVAL.
- iter_cnt behaviour:
  - It holds its value in EVAL, DONE and IDLE.
  - It reads 0 in DONE.
  - No wrap: it never decrements below 0.
- start_valid outside IDLE is ignored and does not queue.
- done_ready outside DONE is ignored.
- flush:
  - Flush high at an edge forces IDLE and iter_cnt <= 0 from any state, so all strobes are low in the next cycle.
  - It has priority over the start handshake and the done handshake in the same cycle.
  - No done_valid is produced for a flushed operation.
- Async reset mid-operation: immediately IDLE with outputs at reset values; the operation is discarded.
- q0/q_m1 are sampled only in EVAL. The datapath guarantees they are stable registered values in that cycle.

Test Plan:
1. Reset with rst low while clocking, start_valid=1 -> start_ready=1; ld, add_en, sub_en, shift_en, busy and done_valid are 0; iter_cnt=0; after release, the first start is accepted.
2. DATA_WIDTH=4, start handshake at edge k, {q0,q_m1} per EVAL = 10,11,01,00:
   - sub_en in EVAL1, none in EVAL2, add_en in EVAL3, none in EVAL4.
   - Four shift_en pulses.
   - iter_cnt goes 4,3,2,1,0.
   - done_valid rises after edge k+9.
3. Hold done_ready=0 for 5 cycles in DONE with start_valid=1 -> done_valid stays 1 and start_ready stays 0. Then done_ready=1 -> IDLE next cycle and the next start is accepted one edge later.
4. Assert flush in the second SHIFT -> all strobes low next cycle, IDLE, iter_cnt=0, no done_valid. Assert flush together with start_valid in IDLE -> no ld.
5. Drop rst asynchronously mid-EVAL while add_en is high -> add_en and busy fall without waiting for a clock edge; a restart then completes normally with done_valid after edge k+9.
6. DATA_WIDTH=8 (CNT_WIDTH=4) -> iter_cnt loads 8, eight shift_en pulses occur, and done_valid rises after edge k+17.
